// File: rtl/ssd_score_driver.sv
// Binary score to 4-digit multiplexed 7-segment display driver.
// Optional macro: SSD_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module ssd_score_driver #(
  parameter int SCAN_W  = 18,
  parameter int SCORE_W = 14
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         ssdOut,
  output logic [3:0]         anode,
  output logic               busy
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_bin;
  logic [SCORE_W-1:0] w_sat;
  logic [15:0]        r_bcd;
  logic [15:0]        w_adj;
  logic [15:0]        r_disp;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cap;
  logic               w_last;

  logic [SCAN_W-1:0]  r_scan;
  logic [1:0]         w_idx;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg;
  logic               w_blank;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;

  assign w_cap  = (score != r_score);
  assign w_last = (r_cnt == CNT_W'(SCORE_W - 1));
  assign w_sat  = (32'(score) > 32'd9999) ?
                  SCORE_W'(9999) : score;
  assign busy   = (r_state != IDLE);

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cap) w_next = CONV;
      CONV:    if (w_last) w_next = LOAD;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_score keeps the raw input so a saturated value is not re-captured
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_score <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cap) begin
            r_score <= score;
            r_bin   <= w_sat;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        CONV: begin
          {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        LOAD: r_disp <= r_bcd;
        default: ;
      endcase
    end
  end

  assign w_idx   = r_scan[SCAN_W-1 -: 2];
  assign w_digit = r_disp[{w_idx, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic w_z3, w_z2, w_z1;
  assign w_z3 = (r_disp[15:12] == 4'd0);
  assign w_z2 = w_z3 && (r_disp[11:8] == 4'd0);
  assign w_z1 = w_z2 && (r_disp[7:4] == 4'd0);

  always_comb begin
    w_blank = 1'b0;
    case (w_idx)
      2'd3:    w_blank = w_z3;
      2'd2:    w_blank = w_z2;
      2'd1:    w_blank = w_z1;
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_scan <= '0;
      r_an   <= 4'b1111;
      r_seg  <= 7'b1111111;
    end else begin
      r_scan <= r_scan + 1'b1;
      r_an   <= w_blank ? 4'b1111 : ~(4'b0001 << w_idx);
      r_seg  <= w_blank ? 7'b1111111 : w_seg;
    end
  end

  assign anode  = r_an;
  assign ssdOut = r_seg;

endmodule

// File: tb/tb_ssd_score_driver.sv
// Scoreboard bench for ssd_score_driver (short scan counter).
// Honours SSD_LEADING_ZERO_BLANK_EN when defined.
module tb_ssd_score_driver;

  localparam int SW = 4;
  localparam int CW = 14;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [15:0] bcd;
    int          k;
  } exp_t;

  logic          Clk;
  logic          Reset;
  logic [CW-1:0] score;
  logic [6:0]    ssdOut;
  logic [3:0]    anode;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rise   = 0;
  bit in_conv = 0;
  exp_t sb[$];
  logic [SW-1:0] m_scan = '0;
  logic [SW-1:0] m_prev = '0;

  ssd_score_driver #(
    .SCAN_W (SW),
    .SCORE_W(CW)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .score (score),
    .ssdOut(ssdOut),
    .anode (anode),
    .busy  (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit blank_of(logic [15:0] b, int i);
    bit z = LZ && (i > 0);
    for (int j = i; j < 4; j++)
      if (b[4*j +: 4] != 4'd0) z = 1'b0;
    return z;
  endfunction

  // Conversion monitor: pops one entry per completed conversion
  always @(posedge Clk) begin
    cyc++;
    if (Reset) m_scan = '0;
    else begin
      m_prev = m_scan;
      m_scan = m_scan + 1'b1;
    end
    #1;
    if (Reset) in_conv = 0;
    else if (!in_conv && busy) begin
      in_conv = 1;
      rise = cyc;
    end else if (in_conv && !busy) begin
      in_conv = 0;
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("busy_rise", rise, e.k);
        check("disp_edge", cyc, e.k + CW + 1);
        check("disp_val", dut.r_disp, e.bcd);
      end
    end
  end

  task automatic set_score(input logic [CW-1:0] v,
                           input logic [15:0] b,
                           input bit push);
    exp_t e;
    @(negedge Clk);
    score = v;
    e.bcd = b;
    e.k = cyc + 1;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (busy && n < 80) begin
      @(negedge Clk);
      n++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  task automatic scan_check(input logic [15:0] b);
    int i;
    logic [3:0] ea;
    logic [6:0] es;
    for (int c = 0; c < 16; c++) begin
      @(posedge Clk);
      #2;
      i = int'(m_prev[SW-1 -: 2]);
      if (blank_of(b, i)) begin
        ea = 4'b1111;
        es = 7'b1111111;
      end else begin
        ea = ~(4'b0001 << i);
        es = seg_of(b[4*i +: 4]);
      end
      check("scan_anode", anode, ea);
      check("scan_seg", ssdOut, es);
    end
  endtask

  initial begin
    exp_t e;
    Reset = 1'b1;
    score = '0;
    repeat (3) @(negedge Clk);
    check("rst_anode", anode, 4'b1111);
    check("rst_seg", ssdOut, 7'b1111111);
    check("rst_busy", busy, 1'b0);
    check("rst_disp", dut.r_disp, 16'h0000);
    Reset = 1'b0;
    scan_check(16'h0000);

    set_score(14'd1234, 16'h1234, 1);
    wait_idle();
    scan_check(16'h1234);

    set_score(14'd12000, 16'h9999, 1);
    wait_idle();
    scan_check(16'h9999);

    set_score(14'd7, 16'h0007, 1);
    wait_idle();
    scan_check(16'h0007);

    set_score(14'd0, 16'h0000, 1);
    wait_idle();
    set_score(14'd50, 16'h0050, 1);
    e.k = cyc + 1 + 16;
    e.bcd = 16'h0051;
    repeat (5) @(negedge Clk);
    score = 14'd51;
    sb.push_back(e);
    wait_idle();
    wait_idle();
    scan_check(16'h0051);

    set_score(14'd0, 16'h0000, 1);
    wait_idle();
    set_score(14'd999, 16'h0000, 0);
    repeat (8) @(negedge Clk);
    check("pre_abort_busy", busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_busy", busy, 1'b0);
    check("abort_disp", dut.r_disp, 16'h0000);
    check("abort_anode", anode, 4'b1111);
    check("abort_seg", ssdOut, 7'b1111111);
    @(negedge Clk);
    Reset = 1'b0;
    e.k = cyc + 1;
    e.bcd = 16'h0999;
    sb.push_back(e);
    wait_idle();
    scan_check(16'h0999);

    repeat (3) @(negedge Clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ssd_score_driver.md
SSD_SCORE_DRIVER -- requirements
Module: ssd_score_driver

Interface
REQ-001 The block SHALL have parameter SCAN_W, default 18, meaning the width of the digit-scan counter; the digit index is the counter's top 2 bits.
REQ-002 The block SHALL have parameter SCORE_W, default 14, meaning the width of the binary score input.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port score, input, SCORE_W bits: the unsigned binary game score from the core.
REQ-006 The block SHALL have port ssdOut, output, 7 bits: cathodes {Ca..Cg} in bits [6:0], active-low.
REQ-007 The block SHALL have port anode, output, 4 bits: digit enables An3..An0, active-low, one-hot-low.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a binary-to-BCD conversion is in progress.

Function
REQ-009 The FSM SHALL have three states: IDLE, CONV and LOAD.
REQ-010 In IDLE, when score differs from the last captured value, the block SHALL at that edge capture score, saturated to 9999 if it is greater than 9999, and go to CONV.
REQ-011 CONV SHALL run exactly SCORE_W double-dabble iterations, one per cycle: add 3 to each BCD nibble that is 5 or more, then shift left 1 bit.
REQ-012 After the last iteration the FSM SHALL go to LOAD; LOAD SHALL copy the 16-bit BCD result into the display register and return to IDLE.
REQ-013 If the capture happens at edge k, the display register SHALL update at edge k+SCORE_W+1 (k+15 by default).
REQ-014 busy SHALL be high in CONV and LOAD and low in IDLE.
REQ-015 Changes to score during CONV or LOAD SHALL be ignored until the FSM is back in IDLE; an unequal value is then captured on the first IDLE edge, so the final value is never lost.
REQ-016 The display register SHALL hold its value between conversions; the display SHALL never show a partial conversion.
REQ-017 The scan counter SHALL be SCAN_W bits, increment every cycle, and wrap from all-ones to 0.
REQ-018 The digit index SHALL be the top 2 bits of the scan counter: 0 selects ones on An0, 1 tens on An1, 2 hundreds on An2, 3 thousands on An3.
REQ-019 ssdOut and anode SHALL be registered, with one cycle of latency from the scan counter.
REQ-020 The segment decode SHALL be standard 0-9, active-low; for example 0 = 7'b0000001 and 8 = 7'b0000000.
REQ-021 BCD nibbles above 9 cannot occur; if one does, it SHALL decode to blank (7'b1111111).

Reset
REQ-022 While Reset is high, the FSM SHALL be in IDLE and the captured score, the BCD shift register, the display register and the scan counter SHALL all be 0.
REQ-023 While Reset is high, anode SHALL be 4'b1111, ssdOut SHALL be 7'b1111111 and busy SHALL be 0.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion without updating the display register.
REQ-025 After Reset is released, a nonzero score SHALL be captured on the first edge.

Configuration
REQ-026 The block SHALL support macro SSD_LEADING_ZERO_BLANK_EN.
REQ-027 With SSD_LEADING_ZERO_BLANK_EN defined, a digit SHALL be blanked (its anode high, ssdOut 7'b1111111) when it and every more-significant digit are 0; the ones digit is never blanked, so a score of 0 shows "0".
REQ-028 Without SSD_LEADING_ZERO_BLANK_EN, all four digits SHALL always be driven, including leading zeros, so a score of 0 shows "0000".

Verification
REQ-029 The bench SHALL cover: Reset high with score=0 -> anode=4'b1111, ssdOut=7'b1111111, busy=0; after release, a full scan shows 0 (or "0000" without the macro).
REQ-030 The bench SHALL cover: score changes 0 -> 1234 at edge k -> busy high from k through k+14, display register 16'h1234 at k+15, and the scan shows 4 on An0, 3 on An1, 2 on An2, 1 on An3.
REQ-031 The bench SHALL cover: score=12000 -> display register 16'h9999, all digits show 9 (7'b0000100).
REQ-032 The bench SHALL cover: score=7 with the macro -> An1..An3 stay high in their slots and An0 shows 7'b0001111; without the macro -> "0007".
REQ-033 The bench SHALL cover: score 0 -> 50 at k, then 50 -> 51 at k+5 (mid-CONV) -> 16'h0050 at k+15, recapture at k+16, 16'h0051 at k+31.
REQ-034 The bench SHALL cover: Reset pulsed at k+8 during a conversion of 999 -> the display register stays at its prior value (0), and after release 999 converts and shows correctly.
